// File: rtl/int_sched.sv
// 8051 interrupt scheduler: polls source flags at instruction boundaries, applies IE/IP rules,
// holds a vectored request until ACK and tracks in-service priority levels for nesting.
module int_sched #(
  parameter int unsigned NSRC  = 5,
  parameter logic [7:0]  VBASE = 8'h03
) (
  input  logic            CLK,
  input  logic            RESET_N,
  input  logic [NSRC-1:0] SRC_FLAG,
  input  logic [7:0]      IE,
  input  logic [NSRC-1:0] IP,
  input  logic [1:0]      IT,
  input  logic            INSTR_END,
  input  logic            INHIBIT,
  input  logic            ACK,
  input  logic            RETI,
  output logic            INT_REQ,
  output logic [7:0]      INT_VECT,
  output logic [2:0]      INT_IDX,
  output logic [1:0]      INT_LEVEL,
  output logic [NSRC-1:0] CLR_FLAG
);

  typedef enum logic [0:0] {StIdle, StPend} state_e;

  state_e          state_q, state_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      vect_q, vect_d;
  logic            hi_q, hi_d;
  logic [1:0]      level_q, level_d;
  logic [NSRC-1:0] clr_q, clr_d;
  logic            post_reti_q, post_reti_d;

  logic [NSRC-1:0] elig, hi_ok, lo_ok, cand;
  logic            win_found, win_hi, poll_en, ack_take;
  logic [2:0]      win_idx;
  logic            unused_ie;

  assign unused_ie = ^IE[6:NSRC];

  // Winner selection: any allowed high source beats low; lowest index within a level.
  always_comb begin
    elig      = SRC_FLAG & IE[NSRC-1:0] & {NSRC{IE[7]}};
    hi_ok     = elig & IP & {NSRC{~level_q[1]}};
    lo_ok     = elig & ~IP & {NSRC{level_q == 2'b00}};
    win_hi    = |hi_ok;
    cand      = win_hi ? hi_ok : lo_ok;
    win_found = |cand;
    win_idx   = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (cand[i]) win_idx = 3'(i);
    end
  end

  assign poll_en  = (state_q == StIdle) && INSTR_END && !INHIBIT && !post_reti_q;
  assign ack_take = (state_q == StPend) && ACK;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      vect_q      <= VBASE;
      hi_q        <= 1'b0;
      level_q     <= 2'b00;
      clr_q       <= '0;
      post_reti_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      vect_q      <= vect_d;
      hi_q        <= hi_d;
      level_q     <= level_d;
      clr_q       <= clr_d;
      post_reti_q <= post_reti_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (poll_en && win_found) state_d = StPend;
      StPend:  if (ACK) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    idx_d       = idx_q;
    vect_d      = vect_q;
    hi_d        = hi_q;
    level_d     = level_q;
    clr_d       = '0;
    post_reti_d = post_reti_q;

    if (poll_en && win_found) begin
      idx_d  = win_idx;
      vect_d = VBASE + {2'b00, win_idx, 3'b000};
      hi_d   = win_hi;
    end

    // RETI clears the old level first so a same-cycle ACK sets on top of it.
    if (RETI) begin
      if (level_q[1])      level_d[1] = 1'b0;
      else if (level_q[0]) level_d[0] = 1'b0;
    end

    if (ack_take) begin
      if (hi_q) level_d[1] = 1'b1;
      else      level_d[0] = 1'b1;
      case (idx_q)
        3'd0:    clr_d[0] = IT[0];
        3'd1:    clr_d[1] = 1'b1;
        3'd2:    clr_d[2] = IT[1];
        3'd3:    clr_d[3] = 1'b1;
        default: clr_d    = '0;
      endcase
    end

    if (RETI)           post_reti_d = 1'b1;
    else if (INSTR_END) post_reti_d = 1'b0;
  end

  always_comb begin
    INT_REQ = (state_q == StPend);
  end

  assign INT_IDX   = idx_q;
  assign INT_VECT  = vect_q;
  assign INT_LEVEL = level_q;
  assign CLR_FLAG  = clr_q;

endmodule

// File: doc/int_sched.md
# int_sched

Interrupt scheduler for the 8051 core. It polls five interrupt source flags at instruction boundaries and applies the IE/IP enable and priority rules. It raises a held request with a vector toward the instruction-extension logic, and tracks the in-service priority levels that gate nesting. Its INT_REQ and INT_LEVEL outputs drive the instruction-extension selector directly.

## Interface
Parameters:
- NSRC, 5, number of sources; index 0..4 = IE0, TF0, IE1, TF1, RI|TI.
- VBASE, 8'h03, vector of source 0; source n vector = VBASE + 8*n.

Ports:
- CLK  in  1  core clock; all state on rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- SRC_FLAG  in  5  latched source flags from peripherals/SFRs.
- IE  in  8  IE SFR; bit7 = EA, bits 4:0 = per-source enable.
- IP  in  5  IP SFR; 1 = high priority.
- IT  in  2  TCON IT0/IT1; 1 = external source 0/2 is edge-triggered.
- INSTR_END  in  1  one-cycle pulse on the last cycle of each instruction (poll point).
- INHIBIT  in  1  current instruction wrote IE/IP; suppresses the poll at this INSTR_END.
- ACK  in  1  one-cycle pulse: core has started the vectored LCALL.
- RETI  in  1  one-cycle pulse: RETI executed.
- INT_REQ  out  1  interrupt request to instruction extension.
- INT_VECT  out  8  vector address of the pending source.
- INT_IDX  out  3  index of the pending source.
- INT_LEVEL  out  2  in-service levels; bit0 = low, bit1 = high.
- CLR_FLAG  out  5  one-cycle hardware-clear pulse toward the flag owners.

## Operation
- FSM states:
  - IDLE: no request.
  - PEND: INT_REQ=1; INT_IDX/INT_VECT held.
- Eligibility: source n is eligible when SRC_FLAG[n] & IE[n] & IE[7].
- Level gating:
  - An eligible high source (IP[n]=1) may be taken only if INT_LEVEL[1]=0.
  - An eligible low source may be taken only if INT_LEVEL==2'b00.
- Selection: any allowed high-priority source beats any low-priority one; within a level, the lowest index wins.
- Poll occurs only in IDLE, on a cycle with INSTR_END=1 and INHIBIT=0 and post_reti=0.
  - A winner moves the FSM to PEND and latches INT_IDX and INT_VECT.
  - No winner leaves the FSM in IDLE.
- post_reti (internal): set by RETI. Cleared at the next INSTR_END, and that INSTR_END does not poll. This guarantees one instruction executes after RETI.
- PEND holds until ACK. Flag deassertion while in PEND does not withdraw the request.
- On ACK in PEND, the FSM returns to IDLE and:
  - sets INT_LEVEL[1] if the pending source was high priority, else INT_LEVEL[0];
  - pulses CLR_FLAG[INT_IDX] for idx 1 or 3 always, for idx 0/2 only when IT[0]/IT[1]=1, and never for idx 4.
- RETI clears INT_LEVEL[1] if set, else INT_LEVEL[0]. RETI with INT_LEVEL==0 leaves INT_LEVEL unchanged.
- Simultaneous RETI and ACK: apply the RETI clear to the old INT_LEVEL first, then the ACK set.
- ACK in IDLE is ignored.
- Reset, asynchronous and effective mid-operation: IDLE, INT_REQ=0, INT_IDX=0, INT_VECT=8'h03, INT_LEVEL=2'b00, CLR_FLAG=0, post_reti=0.

## Timing
- All outputs are registered.
- Poll at INSTR_END in cycle N: INT_REQ, INT_IDX and INT_VECT are valid from cycle N+1.
- ACK in cycle M: in cycle M+1, INT_REQ=0, INT_LEVEL is updated and CLR_FLAG pulses for exactly one cycle.
- Earliest re-poll is the INSTR_END in cycle M+1. That poll sees the updated INT_LEVEL, so a same-level source is blocked.
- RETI in cycle R: INT_LEVEL is updated in R+1.
  - If INSTR_END is also asserted in R, the poll in R is not suppressed (post_reti is not yet set).
  - The following INSTR_END is suppressed.
- INSTR_END in a PEND cycle has no effect.

## Test plan
- Single low source: IE=8'h82, IP=0, SRC_FLAG=5'b00010, INSTR_END -> next cycle INT_REQ=1, INT_IDX=1, INT_VECT=8'h0B; ACK -> INT_LEVEL=01, CLR_FLAG=00010 for 1 cycle.
- Priority: IE=8'h9F, IP=5'b10000, SRC_FLAG=5'b10001 -> INT_IDX=4, INT_VECT=8'h23; after ACK, INT_LEVEL=10 and CLR_FLAG stays 0.
- Nesting: with INT_LEVEL=01, a high source (IP[2]=1, SRC_FLAG[2]=1, IT[1]=0) is taken; ACK -> INT_LEVEL=11 and no CLR_FLAG. A second low source stays blocked until two RETIs return INT_LEVEL to 00.
- RETI shadow: RETI, then INSTR_END with an eligible source -> no request; the next INSTR_END -> INT_REQ=1. INHIBIT=1 at INSTR_END -> no request.
- EA off: IE=8'h1F with all flags set, repeated INSTR_END -> INT_REQ stays 0.
- Reset mid-PEND: assert RESET_N=0 asynchronously while INT_REQ=1 and INT_LEVEL=10 -> immediately INT_REQ=0, INT_LEVEL=00, INT_VECT=8'h03.
